// File: rtl/mem_image_loader.sv
// mem_image_loader: receives a byte frame from a host, packs it into 32-bit
// words and writes them into IMEM or DMEM, holding the core in reset while a
// frame is in flight.
// Frame: HDR(A5=IMEM / 5A=DMEM), CNT[15:0], ADR[15:0] (word address), N*4 data
// bytes, all little-endian. Defining LOADER_CSUM_EN appends a trailing XOR
// checksum byte that must match before the core is released.
module mem_image_loader #(
   parameter int PC_WIDTH        = 10,
   parameter int DATA_ADDR_WIDTH = 10,
   parameter int XLEN            = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [7:0]                 in_data,
   output logic                       in_ready,
   output logic                       imem_we,
   output logic [PC_WIDTH-1:0]        imem_addr,
   output logic                       dmem_we,
   output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
   output logic [XLEN-1:0]            mem_wdata,
   output logic                       core_rst_n,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam logic [7:0] HDR_IMEM = 8'hA5;
   localparam logic [7:0] HDR_DMEM = 8'h5A;
   localparam int         LANES    = XLEN / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT0,
      S_CNT1,
      S_ADR0,
      S_ADR1,
      S_DATA,
      S_WRITE
`ifdef LOADER_CSUM_EN
      ,S_CSUM
`endif
   } state_t;

   state_t                     state_reg, state_next;
   logic                       target_dmem_reg, target_dmem_next;
   logic [15:0]                cnt_reg, cnt_next;
   logic [7:0]                 adr_lo_reg, adr_lo_next;
   logic [1:0]                 byte_idx_reg, byte_idx_next;
   logic [XLEN-1:0]            word_reg, word_next;
   logic [XLEN-1:0]            packed_word;
   logic [PC_WIDTH-1:0]        imem_addr_reg, imem_addr_next;
   logic [DATA_ADDR_WIDTH-1:0] dmem_addr_reg, dmem_addr_next;
   logic                       core_rst_n_reg, core_rst_n_next;
   logic                       done_reg, done_next;
   logic                       accept;
   logic [17:0]                adr_base;
`ifdef LOADER_CSUM_EN
   logic [7:0]                 csum_reg, csum_next;
   logic                       err_reg, err_next;
`endif

   genvar gi;

   assign accept   = in_valid && in_ready;
   // Byte address of the start word: W<<2, built from the latched low byte and
   // the ADR1 byte currently on the bus; truncated to each memory's width.
   assign adr_base = {in_data, adr_lo_reg, 2'b00};

   // Current word with the incoming byte dropped into the lane selected by the
   // byte index (LSB first).
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign packed_word[gi*8 +: 8] = (byte_idx_reg == 2'(gi)) ? in_data
                                                                  : word_reg[gi*8 +: 8];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_dmem_reg <= 1'b0;
         cnt_reg         <= '0;
         adr_lo_reg      <= '0;
         byte_idx_reg    <= '0;
         word_reg        <= '0;
         imem_addr_reg   <= '0;
         dmem_addr_reg   <= '0;
         core_rst_n_reg  <= 1'b1;
         done_reg        <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum_reg        <= '0;
         err_reg         <= 1'b0;
`endif
      end else begin
         target_dmem_reg <= target_dmem_next;
         cnt_reg         <= cnt_next;
         adr_lo_reg      <= adr_lo_next;
         byte_idx_reg    <= byte_idx_next;
         word_reg        <= word_next;
         imem_addr_reg   <= imem_addr_next;
         dmem_addr_reg   <= dmem_addr_next;
         core_rst_n_reg  <= core_rst_n_next;
         done_reg        <= done_next;
`ifdef LOADER_CSUM_EN
         csum_reg        <= csum_next;
         err_reg         <= err_next;
`endif
      end
   end

   // Next-state and datapath update; the FSM advances on each accepted byte,
   // except WRITE which always lasts exactly one cycle.
   always_comb begin
      state_next       = state_reg;
      target_dmem_next = target_dmem_reg;
      cnt_next         = cnt_reg;
      adr_lo_next      = adr_lo_reg;
      byte_idx_next    = byte_idx_reg;
      word_next        = word_reg;
      imem_addr_next   = imem_addr_reg;
      dmem_addr_next   = dmem_addr_reg;
      core_rst_n_next  = core_rst_n_reg;
      done_next        = 1'b0;
`ifdef LOADER_CSUM_EN
      csum_next        = csum_reg;
      err_next         = err_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            // Non-header bytes are silently dropped while idle.
            if (accept && (in_data == HDR_IMEM || in_data == HDR_DMEM)) begin
               target_dmem_next = (in_data == HDR_DMEM);
               core_rst_n_next  = 1'b0;
               byte_idx_next    = '0;
`ifdef LOADER_CSUM_EN
               csum_next        = '0;
               err_next         = 1'b0;
`endif
               state_next       = S_CNT0;
            end
         end
         S_CNT0: begin
            if (accept) begin
               cnt_next[7:0] = in_data;
               state_next    = S_CNT1;
            end
         end
         S_CNT1: begin
            if (accept) begin
               cnt_next[15:8] = in_data;
               state_next     = S_ADR0;
            end
         end
         S_ADR0: begin
            if (accept) begin
               adr_lo_next = in_data;
               state_next  = S_ADR1;
            end
         end
         S_ADR1: begin
            if (accept) begin
               if (target_dmem_reg) begin
                  dmem_addr_next = DATA_ADDR_WIDTH'(adr_base);
               end else begin
                  imem_addr_next = PC_WIDTH'(adr_base);
               end
               if (cnt_reg == 16'd0) begin
`ifdef LOADER_CSUM_EN
                  state_next = S_CSUM;
`else
                  state_next      = S_IDLE;
                  done_next       = 1'b1;
                  core_rst_n_next = 1'b1;
`endif
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               word_next     = packed_word;
               byte_idx_next = byte_idx_reg + 2'd1;
`ifdef LOADER_CSUM_EN
               csum_next     = csum_reg ^ in_data;
`endif
               if (byte_idx_reg == 2'd3) begin
                  state_next = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // The strobe is this cycle; the address steps once it has been used.
            if (target_dmem_reg) begin
               dmem_addr_next = dmem_addr_reg + DATA_ADDR_WIDTH'(4);
            end else begin
               imem_addr_next = imem_addr_reg + PC_WIDTH'(4);
            end
            cnt_next = cnt_reg - 16'd1;
            if (cnt_reg == 16'd1) begin
`ifdef LOADER_CSUM_EN
               state_next = S_CSUM;
`else
               state_next      = S_IDLE;
               done_next       = 1'b1;
               core_rst_n_next = 1'b1;
`endif
            end else begin
               state_next = S_DATA;
            end
         end
`ifdef LOADER_CSUM_EN
         S_CSUM: begin
            // A bad frame leaves the core held until a good frame or rst_n.
            if (accept) begin
               if (in_data == csum_reg) begin
                  done_next       = 1'b1;
                  core_rst_n_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
               state_next = S_IDLE;
            end
         end
`endif
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign in_ready   = (state_reg != S_WRITE);
   assign busy       = (state_reg != S_IDLE);
   assign imem_we    = (state_reg == S_WRITE) && !target_dmem_reg;
   assign dmem_we    = (state_reg == S_WRITE) &&  target_dmem_reg;
   assign imem_addr  = imem_addr_reg;
   assign dmem_addr  = dmem_addr_reg;
   assign mem_wdata  = word_reg;
   assign core_rst_n = core_rst_n_reg;
   assign done       = done_reg;
`ifdef LOADER_CSUM_EN
   assign err        = err_reg;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: drives byte frames (directed and random) into the
// loader and compares memory writes and status against a frame-level model.
`timescale 1ns/1ps
module tb_mem_image_loader;

   localparam int PC_WIDTH        = 10;
   localparam int DATA_ADDR_WIDTH = 10;
   localparam int XLEN            = 32;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       in_valid = 1'b0;
   logic [7:0]                 in_data = 8'h00;
   logic                       in_ready;
   logic                       imem_we;
   logic [PC_WIDTH-1:0]        imem_addr;
   logic                       dmem_we;
   logic [DATA_ADDR_WIDTH-1:0] dmem_addr;
   logic [XLEN-1:0]            mem_wdata;
   logic                       core_rst_n;
   logic                       busy;
   logic                       done;
   logic                       err;

   mem_image_loader #(
      .PC_WIDTH(PC_WIDTH),
      .DATA_ADDR_WIDTH(DATA_ADDR_WIDTH),
      .XLEN(XLEN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .dmem_we(dmem_we),
      .dmem_addr(dmem_addr),
      .mem_wdata(mem_wdata),
      .core_rst_n(core_rst_n),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dmem;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         obs_q[$];
   logic [7:0]  bq[$];
   logic [31:0] fw [0:15];
   int          n_checks = 0;
   int          n_fail = 0;
   int          obs_done = 0;
   int          exp_done = 0;
   int          exp_imem_addr = 0;
   int          exp_dmem_addr = 0;
   logic        exp_err = 1'b0;
   logic        exp_core = 1'b1;
   bit          mon_en = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-cycle observer: records write strobes and done pulses, checks invariants.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check_eq("we_onehot", 32'(imem_we & dmem_we), 32'd0);
         check_eq("ready_vs_we", 32'(in_ready), 32'(!(imem_we || dmem_we)));
         if (busy) check_eq("core_held", 32'(core_rst_n), 32'd0);
         if (done) begin
            obs_done++;
            check_eq("core_on_done", 32'(core_rst_n), 32'd1);
         end
         if (imem_we) obs_q.push_back('{dmem: 1'b0, addr: 16'(imem_addr), data: mem_wdata});
         if (dmem_we) obs_q.push_back('{dmem: 1'b1, addr: 16'(dmem_addr), data: mem_wdata});
      end
   end

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waited < 16) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_stream(input bit gaps, input int count);
      for (int i = 0; i < count; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         send_byte(bq[i]);
      end
      in_valid = 1'b0;
   endtask

   // Serialise a frame from fw[0..n-1].
   task automatic build_frame(input bit dmem, input int w, input int n, input bit bad);
      logic [7:0] cs;
      logic [7:0] b;
      bq.delete();
      bq.push_back(dmem ? 8'h5A : 8'hA5);
      bq.push_back(n[7:0]);
      bq.push_back(n[15:8]);
      bq.push_back(w[7:0]);
      bq.push_back(w[15:8]);
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = fw[i][8*k +: 8];
            bq.push_back(b);
            cs = cs ^ b;
         end
      end
`ifdef LOADER_CSUM_EN
      bq.push_back(bad ? (cs ^ 8'h01) : cs);
`else
      if (bad) bq.push_back(cs);
`endif
   endtask

   // Frame-level model: word i goes to ((W+i)*4) mod 2^width.
   task automatic expect_frame(input bit dmem, input int w, input int n, input bit bad);
      int mask;
      mask = dmem ? ((1 << DATA_ADDR_WIDTH) - 1) : ((1 << PC_WIDTH) - 1);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{dmem: dmem, addr: 16'(((w + i) * 4) & mask), data: fw[i]});
      end
      if (dmem) exp_dmem_addr = ((w + n) * 4) & mask;
      else      exp_imem_addr = ((w + n) * 4) & mask;
`ifdef LOADER_CSUM_EN
      if (bad) begin
         exp_err  = 1'b1;
         exp_core = 1'b0;
      end else begin
         exp_err  = 1'b0;
         exp_core = 1'b1;
         exp_done++;
      end
`else
      exp_err  = 1'b0;
      exp_core = 1'b1;
      exp_done++;
`endif
   endtask

   task automatic finish_frame(input string name);
      repeat (4) @(negedge clk);
      check_eq({name, ":n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check_eq({name, ":wr_tgt"}, 32'(obs_q[i].dmem), 32'(exp_q[i].dmem));
         check_eq({name, ":wr_addr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
         check_eq({name, ":wr_data"}, obs_q[i].data, exp_q[i].data);
      end
      check_eq({name, ":done_cnt"}, 32'(obs_done), 32'(exp_done));
      check_eq({name, ":busy"}, 32'(busy), 32'd0);
      check_eq({name, ":err"}, 32'(err), 32'(exp_err));
      check_eq({name, ":core_rst_n"}, 32'(core_rst_n), 32'(exp_core));
      check_eq({name, ":imem_addr"}, 32'(imem_addr), 32'(exp_imem_addr));
      check_eq({name, ":dmem_addr"}, 32'(dmem_addr), 32'(exp_dmem_addr));
      obs_q.delete();
      exp_q.delete();
      obs_done = 0;
      exp_done = 0;
   endtask

   task automatic run_frame(input string name, input bit dmem, input int w, input int n,
                            input bit bad, input bit gaps);
      build_frame(dmem, w, n, bad);
      expect_frame(dmem, w, n, bad);
      send_stream(gaps, bq.size());
      finish_frame(name);
   endtask

   task automatic check_reset(input string name);
      check_eq({name, ":in_ready"}, 32'(in_ready), 32'd1);
      check_eq({name, ":imem_we"}, 32'(imem_we), 32'd0);
      check_eq({name, ":dmem_we"}, 32'(dmem_we), 32'd0);
      check_eq({name, ":imem_addr"}, 32'(imem_addr), 32'd0);
      check_eq({name, ":dmem_addr"}, 32'(dmem_addr), 32'd0);
      check_eq({name, ":mem_wdata"}, mem_wdata, 32'd0);
      check_eq({name, ":core_rst_n"}, 32'(core_rst_n), 32'd1);
      check_eq({name, ":busy"}, 32'(busy), 32'd0);
      check_eq({name, ":done"}, 32'(done), 32'd0);
      check_eq({name, ":err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] g;
      int         w;
      int         n;
      bit         dm;
      bit         bad;

      repeat (3) @(negedge clk);
      check_reset("por_low");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("por");
      mon_en = 1'b1;

      // Good IMEM frame, with random valid gaps.
      fw[0] = 32'h0000_0013;
      fw[1] = 32'h0010_0093;
      run_frame("imem_good", 1'b0, 0, 2, 1'b0, 1'b1);

`ifdef LOADER_CSUM_EN
      run_frame("bad_csum", 1'b0, 0, 2, 1'b1, 1'b0);
      run_frame("recover", 1'b0, 0, 2, 1'b0, 1'b1);
`endif

      // DMEM frame with no data words.
      run_frame("dmem_n0", 1'b1, 16'h0010, 0, 1'b0, 1'b0);

      // Garbage bytes before a header are ignored.
      send_byte(8'h00);
      check_eq("garbage0:busy", 32'(busy), 32'd0);
      send_byte(8'hFF);
      check_eq("garbage1:busy", 32'(busy), 32'd0);
      fw[0] = 32'hDEAD_BEEF;
      run_frame("garbage_hdr", 1'b1, 16'h00FF, 1, 1'b0, 1'b0);

      // in_valid held high through the whole frame.
      fw[0] = 32'h0000_0013;
      fw[1] = 32'h0010_0093;
      run_frame("backpressure", 1'b0, 0, 2, 1'b0, 1'b0);

      // rst_n during the second data word: first word stays written.
      fw[0] = 32'hCAFE_0001;
      fw[1] = 32'hCAFE_0002;
      build_frame(1'b0, 16'h0020, 2, 1'b0);
      expect_frame(1'b0, 16'h0020, 1, 1'b0);
      // Reset wipes the frame's status and both address registers.
      exp_done      = 0;
      exp_imem_addr = 0;
      exp_dmem_addr = 0;
      exp_err       = 1'b0;
      exp_core      = 1'b1;
      send_stream(1'b0, 11);
      rst_n = 1'b0;
      #2;
      check_reset("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      finish_frame("mid_rst");
      fw[0] = 32'h1234_5678;
      fw[1] = 32'h9ABC_DEF0;
      run_frame("after_rst", 1'b1, 16'h0003, 2, 1'b0, 1'b0);

      // Random frames, each preceded by a non-header byte.
      for (int it = 0; it < 20; it++) begin
         g = 8'($urandom);
         if (g == 8'hA5 || g == 8'h5A) g = 8'h00;
         send_byte(g);
         in_valid = 1'b0;
         check_eq("rand_garbage:busy", 32'(busy), 32'd0);
         w   = int'($urandom_range(0, 65535));
         n   = int'($urandom_range(0, 4));
         dm  = 1'($urandom_range(0, 1));
`ifdef LOADER_CSUM_EN
         bad = ($urandom_range(0, 3) == 0);
`else
         bad = 1'b0;
`endif
         for (int i = 0; i < n; i++) fw[i] = $urandom;
         run_frame("random", dm, w, n, bad, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
